// File: rtl/mac_feeder_if.sv
// rtl/mac_feeder_if.sv - operand, MAC and result signal bundle for mac_feeder
//
// Purpose: groups the operand stream, the MAC operand/result bus and the
//          result stream into one interface.
// Signals:
//   in_valid/in_ready/in_a/in_b/in_last : operand-pair stream into the feeder
//   mac_a/mac_b/mac_clr_n               : operands and clear to the external MAC
//   mac_out                             : accumulated result from the MAC
//   res_valid/res_ready/res_data        : captured dot-product result stream
// Modports: slave = feeder side, master = surrounding environment.
interface mac_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_last;
  logic [31:0] mac_a;
  logic [31:0] mac_b;
  logic        mac_clr_n;
  logic [31:0] mac_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;

  modport slave (
    input  in_valid, in_a, in_b, in_last, mac_out, res_ready,
    output in_ready, mac_a, mac_b, mac_clr_n, res_valid, res_data
  );

  modport master (
    output in_valid, in_a, in_b, in_last, mac_out, res_ready,
    input  in_ready, mac_a, mac_b, mac_clr_n, res_valid, res_data
  );
endinterface

// File: rtl/mac_feeder.sv
// rtl/mac_feeder.sv - buffers an operand vector and streams it through an external MAC
//
// Purpose: collects up to DEPTH operand pairs, clears the MAC, streams the
//          pairs one per cycle, flushes the MAC pipeline with zeros and holds
//          the captured dot product until the consumer takes it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mac_feeder_if.slave (operand stream, MAC bus, result stream)
//   busy       : high whenever the FSM is not in IDLE
//   overflow   : sticky, a vector was cut at DEPTH pairs
module mac_feeder #(
  parameter int DEPTH   = 8,
  parameter int MAC_LAT = 3,
  parameter int CLR_CYC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mac_feeder_if.slave  bus,
  output logic         busy,
  output logic         overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int IW   = AW + 1;
  localparam int CMAX = (CLR_CYC > MAC_LAT) ? CLR_CYC : MAC_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [IW-1:0] DEPTH_W  = IW'(DEPTH);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(MAC_LAT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, STREAM, DRAIN, RESULT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] count_q, count_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [31:0]   mac_a_q, mac_a_d;
  logic [31:0]   mac_b_q, mac_b_d;
  logic          mac_clr_n_q, mac_clr_n_d;
  logic [31:0]   res_data_q, res_data_d;
  logic          in_ready_q, in_ready_d;
  logic          overflow_q, overflow_d;

  logic [31:0]   mem_a_q [DEPTH];
  logic [31:0]   mem_b_q [DEPTH];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          xfer;

  // in_ready_q is only ever high in IDLE/LOAD, so it alone qualifies a beat.
  assign xfer = bus.in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    cyc_d      = cyc_q;
    overflow_d = overflow_q;
    res_data_d = res_data_q;
    wr_en      = 1'b0;
    wr_addr    = count_q[AW-1:0];

    case (state_q)
      IDLE: begin
        if (xfer) begin
          wr_en   = 1'b1;
          count_d = IW'(1);
          cyc_d   = '0;
          state_d = bus.in_last ? CLEAR : LOAD;
        end
      end
      LOAD: begin
        if (xfer) begin
          wr_en   = 1'b1;
          count_d = count_q + IW'(1);
          cyc_d   = '0;
          if (bus.in_last) begin
            state_d = CLEAR;
          end else if (count_d == DEPTH_W) begin
            // Buffer full with no in_last: cut the vector here, the
            // remaining beats start the next one.
            state_d    = CLEAR;
            overflow_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (cyc_q == CLR_LAST) begin
          state_d = STREAM;
          idx_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      STREAM: begin
        if (idx_q == count_q - IW'(1)) begin
          state_d = DRAIN;
          cyc_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DRAIN: begin
        if (cyc_q == LAT_LAST) begin
          state_d    = RESULT;
          res_data_d = bus.mac_out;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      RESULT: begin
        if (bus.res_ready) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered outputs are computed from the next state so they line up
    // with the state the FSM is in during the same cycle.
    in_ready_d  = (state_d == IDLE) || (state_d == LOAD);
    mac_clr_n_d = (state_d != CLEAR);
    mac_a_d     = (state_d == STREAM) ? mem_a_q[idx_d[AW-1:0]] : 32'h0;
    mac_b_d     = (state_d == STREAM) ? mem_b_q[idx_d[AW-1:0]] : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      cyc_q       <= '0;
      mac_a_q     <= 32'h0;
      mac_b_q     <= 32'h0;
      mac_clr_n_q <= 1'b1;
      res_data_q  <= 32'h0;
      in_ready_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      cyc_q       <= cyc_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_clr_n_q <= mac_clr_n_d;
      res_data_q  <= res_data_d;
      in_ready_q  <= in_ready_d;
      overflow_q  <= overflow_d;
    end
  end

  // Pair storage needs no reset: count_q governs which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_a_q[wr_addr] <= bus.in_a;
      mem_b_q[wr_addr] <= bus.in_b;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.mac_clr_n = mac_clr_n_q;
  assign bus.res_valid = (state_q == RESULT);
  assign bus.res_data  = res_data_q;
  assign busy          = (state_q != IDLE);
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_mac_feeder.sv
// tb/tb_mac_feeder.sv - directed self-checking bench for mac_feeder
module tb_mac_feeder;
  localparam int DEPTH   = 8;
  localparam int MAC_LAT = 3;
  localparam int CLR_CYC = 1;

  localparam logic [31:0] F1  = 32'h3F800000;
  localparam logic [31:0] F2  = 32'h40000000;
  localparam logic [31:0] F3  = 32'h40400000;
  localparam logic [31:0] F4  = 32'h40800000;
  localparam logic [31:0] F5  = 32'h40A00000;
  localparam logic [31:0] F6  = 32'h40C00000;
  localparam logic [31:0] F8  = 32'h41000000;
  localparam logic [31:0] F25 = 32'h41C80000;
  localparam logic [31:0] F44 = 32'h42300000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic overflow;

  mac_feeder_if bus();

  mac_feeder #(.DEPTH(DEPTH), .MAC_LAT(MAC_LAT), .CLR_CYC(CLR_CYC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return 32'h0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Behavioural MAC: accumulator plus two output stages (3-cycle latency).
  real         acc = 0.0;
  logic [31:0] pipe1 = 32'h0;
  logic [31:0] pipe2 = 32'h0;
  assign bus.mac_out = pipe2;

  always @(posedge clk) begin
    acc   <= bus.mac_clr_n ? acc + f2r(bus.mac_a) * f2r(bus.mac_b) : 0.0;
    pipe1 <= r2f(acc);
    pipe2 <= pipe1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          clr_total = 0;
  logic [31:0] s_val_q[$];
  int          s_cyc_q[$];
  logic [31:0] r_val_q[$];
  int          r_cyc_q[$];

  always @(negedge clk) begin
    if (!bus.mac_clr_n) clr_total <= clr_total + 1;
    if (bus.mac_a != 32'h0) begin
      s_val_q.push_back(bus.mac_a);
      s_cyc_q.push_back(cyc);
    end
    if (bus.res_valid && bus.res_ready) begin
      r_val_q.push_back(bus.res_data);
      r_cyc_q.push_back(cyc);
    end
  end

  int n_vec = 0;
  int n_bad = 0;
  int r_rd  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last,
                      output int t);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 32'(bus.in_ready), 32'd1);
    t = cyc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic get_res(output logic [31:0] d, output int c);
    int n = 0;
    while (r_val_q.size() <= r_rd && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("result_seen", 32'(r_val_q.size() > r_rd), 32'd1);
    if (r_val_q.size() > r_rd) begin
      d = r_val_q[r_rd];
      c = r_cyc_q[r_rd];
      r_rd++;
    end else begin
      d = 'x;
      c = -1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int          t;
    int          c;
    int          n;
    int          bad;
    int          base_clr;
    int          base_s;
    logic [31:0] d;
    logic [31:0] d0;
    logic [31:0] exp_a [3];

    bus.in_valid  = 1'b0;
    bus.in_a      = 32'h0;
    bus.in_b      = 32'h0;
    bus.in_last   = 1'b0;
    bus.res_ready = 1'b1;
    exp_a[0] = F1;
    exp_a[1] = F3;
    exp_a[2] = F5;

    // Reset values, then in_ready on the first edge after release.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_clr_n", 32'(bus.mac_clr_n), 32'd1);
    chk("rst_mac_a", bus.mac_a, 32'h0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", bus.res_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single pair 5.0 * 5.0.
    base_clr = clr_total;
    base_s   = s_val_q.size();
    send(F5, F5, 1'b1, t);
    get_res(d, c);
    chk("single_data", d, F25);
    chk("single_latency", 32'(c - t), 32'd6);
    chk("single_clr_cycles", 32'(clr_total - base_clr), 32'd1);
    chk("single_stream_cycles", 32'(s_val_q.size() - base_s), 32'd1);
    @(negedge clk);
    chk("single_idle_busy", 32'(busy), 32'd0);

    // Three pairs (1,2),(3,4),(5,6) -> 44.0.
    base_clr = clr_total;
    base_s   = s_val_q.size();
    send(F1, F2, 1'b0, t);
    send(F3, F4, 1'b0, t);
    send(F5, F6, 1'b1, t);
    get_res(d, c);
    chk("three_data", d, F44);
    chk("three_latency", 32'(c - t), 32'd8);
    chk("three_clr_cycles", 32'(clr_total - base_clr), 32'd1);
    chk("three_stream_cycles", 32'(s_val_q.size() - base_s), 32'd3);
    if (s_val_q.size() - base_s >= 3) begin
      chk("three_no_gaps", 32'(s_cyc_q[base_s+2] - s_cyc_q[base_s]), 32'd2);
      for (int i = 0; i < 3; i++) chk("three_order", s_val_q[base_s+i], exp_a[i]);
    end
    chk("three_overflow", 32'(overflow), 32'd0);

    // Consumer stalls 10 cycles in RESULT while in_valid pulses.
    bus.res_ready = 1'b0;
    send(F2, F3, 1'b1, t);
    n = 0;
    while (!bus.res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_res_valid", 32'(bus.res_valid), 32'd1);
    d0 = bus.res_data;
    chk("hold_data", d0, F6);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.res_valid || bus.res_data !== d0 || bus.in_ready) bad++;
      bus.in_valid = i[0];
      bus.in_a     = 32'hDEADBEEF;
      bus.in_b     = 32'h12345678;
    end
    bus.in_valid = 1'b0;
    chk("hold_stable_bad_cycles", 32'(bad), 32'd0);
    bus.res_ready = 1'b1;
    get_res(d, c);
    chk("hold_handshake_data", d, F6);
    @(negedge clk);
    chk("hold_released_valid", 32'(bus.res_valid), 32'd0);
    chk("hold_released_ready", 32'(bus.in_ready), 32'd1);

    // Ten pairs without in_last: first 8 form a vector, 9-10 the next.
    base_s = s_val_q.size();
    for (int i = 0; i < 8; i++) send(F1, F1, 1'b0, t);
    send(F1, F2, 1'b0, t);
    send(F1, F2, 1'b1, t);
    get_res(d, c);
    chk("ovf_first_data", d, F8);
    get_res(d, c);
    chk("ovf_second_data", d, F4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_stream_cycles", 32'(s_val_q.size() - base_s), 32'd10);

    // Reset while streaming entry 2.
    send(F1, F1, 1'b0, t);
    send(F2, F1, 1'b0, t);
    send(F3, F1, 1'b0, t);
    send(F4, F1, 1'b1, t);
    n = 0;
    while (cyc < t + 4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_entry2", bus.mac_a, F3);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_clr_n", 32'(bus.mac_clr_n), 32'd1);
    chk("abort_mac_a", bus.mac_a, 32'h0);
    chk("abort_mac_b", bus.mac_b, 32'h0);
    chk("abort_res_valid", 32'(bus.res_valid), 32'd0);
    chk("abort_res_data", bus.res_data, 32'h0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_partial", 32'(r_val_q.size()), 32'(r_rd));
    send(F5, F5, 1'b1, t);
    get_res(d, c);
    chk("abort_next_data", d, F25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
